trap_sequencer: RTL and testbench



---
 rtl/trap_sequencer_if.sv | 30 +++
 rtl/trap_sequencer.sv | 64 ++++++
 tb/tb_trap_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: execute/CSR-file/fetch signals seen by the trap sequencer.
// The slave side is the sequencer; the master side drives requests and CSR values.
interface trap_sequencer_if;
   logic        i_TrapRequest;
   logic [2:0]  i_ExceptionSource;
   logic [31:0] i_TrapPc;
   logic [31:0] i_TrapValue;
   logic        i_MretRequest;
   logic [31:0] i_Mtvec;
   logic [31:0] i_Mepc;
   logic        i_CsrStall;
   logic        o_Busy;
   logic        o_CsrWriteEnable;
   logic [11:0] o_CsrNumber;
   logic [31:0] o_CsrWriteData;
   logic        o_Redirect;
   logic [31:0] o_RedirectPc;
   modport slave (
      input  i_TrapRequest, i_ExceptionSource, i_TrapPc, i_TrapValue,
      input  i_MretRequest, i_Mtvec, i_Mepc, i_CsrStall,
      output o_Busy, o_CsrWriteEnable, o_CsrNumber, o_CsrWriteData,
      output o_Redirect, o_RedirectPc
   );
   modport master (
      output i_TrapRequest, i_ExceptionSource, i_TrapPc, i_TrapValue,
      output i_MretRequest, i_Mtvec, i_Mepc, i_CsrStall,
      input  o_Busy, o_CsrWriteEnable, o_CsrNumber, o_CsrWriteData,
      input  o_Redirect, o_RedirectPc
   );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry (mepc/mcause/mtval writes, then mtvec redirect) and MRET exit.
module trap_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic             i_Clock,
   input logic             i_Reset,
   trap_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT_TRAP, REDIRECT_MRET} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, tval_q, tval_d;
   logic [3:0]  cause_q, cause_d, cause_map;
   logic        take_trap;
   assign take_trap = bus.i_TrapRequest && (bus.i_ExceptionSource != 3'd0);
   // Reserved source 7 falls into the illegal-instruction code.
   assign cause_map = (bus.i_ExceptionSource == 3'd2) ? 4'd2  :
                      (bus.i_ExceptionSource == 3'd3) ? 4'd3  :
                      (bus.i_ExceptionSource == 3'd4) ? 4'd4  :
                      (bus.i_ExceptionSource == 3'd5) ? 4'd6  :
                      (bus.i_ExceptionSource == 3'd6) ? 4'd11 :
                      (bus.i_ExceptionSource == 3'd7) ? 4'd2  : 4'd0;
   always_ff @(posedge i_Clock or posedge i_Reset)
      if (i_Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
      end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      tval_d  = tval_q;
      case (state_q)
         IDLE:
            if (take_trap) begin
               state_d = WR_EPC;
               pc_d    = {bus.i_TrapPc[31:2], 2'b00};
               cause_d = cause_map;
               tval_d  = (bus.i_ExceptionSource == 3'd6) ? 32'd0 : bus.i_TrapValue;
            end else if (bus.i_MretRequest) state_d = REDIRECT_MRET;
         WR_EPC:   state_d = bus.i_CsrStall ? WR_EPC   : WR_CAUSE;
         WR_CAUSE: state_d = bus.i_CsrStall ? WR_CAUSE : WR_TVAL;
         WR_TVAL:  state_d = bus.i_CsrStall ? WR_TVAL  : REDIRECT_TRAP;
         default:  state_d = IDLE;
      endcase
   end
   assign bus.o_Busy           = state_q != IDLE;
   assign bus.o_CsrWriteEnable = state_q inside {WR_EPC, WR_CAUSE, WR_TVAL};
   assign bus.o_CsrNumber      = (state_q == WR_EPC)   ? 12'h341 :
                                 (state_q == WR_CAUSE) ? 12'h342 :
                                 (state_q == WR_TVAL)  ? 12'h343 : 12'h000;
   assign bus.o_CsrWriteData   = (state_q == WR_EPC)   ? pc_q             :
                                 (state_q == WR_CAUSE) ? {28'd0, cause_q} :
                                 (state_q == WR_TVAL)  ? tval_q           : 32'd0;
   assign bus.o_Redirect       = state_q inside {REDIRECT_TRAP, REDIRECT_MRET};
   assign bus.o_RedirectPc     = (state_q == REDIRECT_TRAP) ? {bus.i_Mtvec[31:2], 2'b00} :
                                 (state_q == REDIRECT_MRET) ? {bus.i_Mepc[31:2], 2'b00}  : RESET_PC;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: table-driven trap sequences per source plus directed stall/reset/MRET corner cases.
module tb_trap_sequencer;
   localparam logic [31:0] RP = 32'h0000_0F00;
   logic i_Clock = 1'b0;
   logic i_Reset = 1'b1;
   int   passed = 0;
   int   total  = 0;
   trap_sequencer_if bus ();
   trap_sequencer #(.RESET_PC(RP)) dut (.i_Clock(i_Clock), .i_Reset(i_Reset), .bus(bus));
   always #5 i_Clock = ~i_Clock;
   typedef struct {
      logic [2:0]  src;
      logic [31:0] pc;
      logic [31:0] tval;
      logic [31:0] mtvec;
      logic [31:0] cause;
      logic [31:0] xtval;
   } vec_t;
   vec_t vecs[7];
   task automatic step();
      @(posedge i_Clock);
      #1;
   endtask
   task automatic expect_out(string nm, logic busy, logic we, logic [11:0] num, logic [31:0] data,
                             logic red, logic [31:0] rpc);
      logic [78:0] got, exp;
      got = {bus.o_Busy, bus.o_CsrWriteEnable, bus.o_CsrNumber, bus.o_CsrWriteData, bus.o_Redirect, bus.o_RedirectPc};
      exp = {busy, we, num, data, red, rpc};
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got busy=%b we=%b num=%h data=%h red=%b pc=%h, need busy=%b we=%b num=%h data=%h red=%b pc=%h",
                    nm, got[78], got[77], got[76:65], got[64:33], got[32], got[31:0],
                    busy, we, num, data, red, rpc);
   endtask
   task automatic exp_idle(string nm);
      expect_out(nm, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0, RP);
   endtask
   task automatic exp_wr(string nm, logic [11:0] num, logic [31:0] data);
      expect_out(nm, 1'b1, 1'b1, num, data, 1'b0, RP);
   endtask
   task automatic exp_red(string nm, logic [31:0] pc);
      expect_out(nm, 1'b1, 1'b0, 12'h000, 32'd0, 1'b1, pc);
   endtask
   task automatic trap(logic [2:0] src, logic [31:0] pc, logic [31:0] tval, logic mret);
      bus.i_TrapRequest = 1'b1;
      bus.i_ExceptionSource = src;
      bus.i_TrapPc = pc;
      bus.i_TrapValue = tval;
      bus.i_MretRequest = mret;
      step();
      bus.i_TrapRequest = 1'b0;
      bus.i_MretRequest = 1'b0;
      bus.i_ExceptionSource = 3'd0;
      bus.i_TrapPc = 32'h5555_5555;
      bus.i_TrapValue = 32'h7777_7777;
   endtask
   initial begin
      vecs[0] = '{3'd1, 32'h1000_0003, 32'h1111_1111, 32'h0000_8001, 32'd0,  32'h1111_1111};
      vecs[1] = '{3'd2, 32'h2000_0004, 32'h0000_1234, 32'h0000_8002, 32'd2,  32'h0000_1234};
      vecs[2] = '{3'd3, 32'h3000_0002, 32'h3333_0000, 32'h0000_8003, 32'd3,  32'h3333_0000};
      vecs[3] = '{3'd4, 32'h4000_0001, 32'h4000_0001, 32'hFFFF_FFFF, 32'd4,  32'h4000_0001};
      vecs[4] = '{3'd5, 32'h5000_000E, 32'h5000_0006, 32'h0000_0104, 32'd6,  32'h5000_0006};
      vecs[5] = '{3'd6, 32'h0000_1006, 32'hDEAD_BEEF, 32'h0000_0101, 32'd11, 32'h0000_0000};
      vecs[6] = '{3'd7, 32'h7000_0007, 32'hCAFE_F00D, 32'h0000_0200, 32'd2,  32'hCAFE_F00D};
      bus.i_TrapRequest = 1'b0;
      bus.i_ExceptionSource = 3'd0;
      bus.i_TrapPc = 32'd0;
      bus.i_TrapValue = 32'd0;
      bus.i_MretRequest = 1'b0;
      bus.i_Mtvec = 32'd0;
      bus.i_Mepc = 32'd0;
      bus.i_CsrStall = 1'b0;
      #1;
      exp_idle("reset_state");
      step();
      step();
      i_Reset = 1'b0;
      step();
      exp_idle("after_reset");
      foreach (vecs[i]) begin
         bus.i_Mtvec = vecs[i].mtvec;
         trap(vecs[i].src, vecs[i].pc, vecs[i].tval, 1'b0);
         exp_wr($sformatf("v%0d_epc", i), 12'h341, {vecs[i].pc[31:2], 2'b00});
         step();
         exp_wr($sformatf("v%0d_cause", i), 12'h342, vecs[i].cause);
         step();
         exp_wr($sformatf("v%0d_tval", i), 12'h343, vecs[i].xtval);
         step();
         exp_red($sformatf("v%0d_redirect", i), {vecs[i].mtvec[31:2], 2'b00});
         step();
         exp_idle($sformatf("v%0d_idle", i));
      end
      // Illegal instruction, mcause write stalled two cycles.
      bus.i_Mtvec = 32'h0000_0300;
      trap(3'd2, 32'h0000_4000, 32'hFFFF_FFFF, 1'b0);
      exp_wr("stall_epc", 12'h341, 32'h0000_4000);
      step();
      bus.i_CsrStall = 1'b1;
      exp_wr("stall_cause0", 12'h342, 32'd2);
      step();
      exp_wr("stall_cause1", 12'h342, 32'd2);
      step();
      bus.i_CsrStall = 1'b0;
      exp_wr("stall_cause2", 12'h342, 32'd2);
      step();
      exp_wr("stall_tval", 12'h343, 32'hFFFF_FFFF);
      step();
      exp_red("stall_redirect", 32'h0000_0300);
      step();
      exp_idle("stall_idle");
      // Back-to-back: MRET accepted in the first idle cycle.
      bus.i_Mepc = 32'h0000_2002;
      bus.i_MretRequest = 1'b1;
      step();
      bus.i_MretRequest = 1'b0;
      exp_red("mret_redirect", 32'h0000_2000);
      step();
      exp_idle("mret_idle");
      // Simultaneous trap and MRET: trap wins.
      bus.i_Mtvec = 32'h0000_0400;
      trap(3'd3, 32'h0000_6008, 32'h0000_0ABC, 1'b1);
      exp_wr("both_epc", 12'h341, 32'h0000_6008);
      step();
      exp_wr("both_cause", 12'h342, 32'd3);
      step();
      exp_wr("both_tval", 12'h343, 32'h0000_0ABC);
      step();
      exp_red("both_redirect", 32'h0000_0400);
      step();
      exp_idle("both_idle");
      // Source 0 is ignored.
      trap(3'd0, 32'h0000_8000, 32'h1, 1'b0);
      exp_idle("src0_a");
      step();
      exp_idle("src0_b");
      // Reset in WR_CAUSE aborts the sequence immediately.
      trap(3'd4, 32'h0000_9000, 32'h0000_9001, 1'b0);
      step();
      exp_wr("rst_cause", 12'h342, 32'd4);
      i_Reset = 1'b1;
      #1;
      exp_idle("rst_async");
      step();
      i_Reset = 1'b0;
      exp_idle("rst_held");
      step();
      exp_idle("rst_after1");
      step();
      exp_idle("rst_after2");
      bus.i_Mepc = 32'h0000_A00F;
      bus.i_MretRequest = 1'b1;
      step();
      bus.i_MretRequest = 1'b0;
      exp_red("rst_mret", 32'h0000_A00C);
      step();
      exp_idle("rst_mret_idle");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
